// File: rtl/outlier_pkg.sv
// Shared lane geometry and types for the outlier weight encoder and unpacker.
// Field offsets describe the addr side channel: {outlier lane, donor lane}.
package outlier_pkg;

    localparam int LANES           = 8;
    localparam int LANE_W          = 8;
    localparam int NIB_W           = 4;
    localparam int ADDR_W          = 3;
    localparam int OUT_FIELD_LSB   = 3;
    localparam int DONOR_FIELD_LSB = 0;

    typedef logic [LANES-1:0]       lane_mask_t;
    typedef logic [ADDR_W-1:0]      lane_idx_t;
    typedef logic [LANES*NIB_W-1:0] nib_vec_t;

    typedef struct packed {
        lane_mask_t out_mask;
        lane_mask_t zero_mask;
        nib_vec_t   hi;
        nib_vec_t   lo;
    } s1_t;

    function automatic logic [3:0] popcnt(lane_mask_t m);
        logic [3:0] c;
        c = '0;
        for (int k = 0; k < LANES; k++) begin
            c = c + 4'(m[k]);
        end
        return c;
    endfunction

endpackage

// File: rtl/outlier_weight_encoder_if.sv
// Weight-in / packed-out valid/ready bundle of the outlier weight encoder.
// master drives weights and consumes packed beats; slave is the encoder.
interface outlier_weight_encoder_if;
    import outlier_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*LANE_W-1:0] w_i;
    logic                    out_valid;
    logic                    out_ready;
    nib_vec_t                w_o;
    logic                    sel_o;
    logic [2*ADDR_W-1:0]     addr_o;
    logic                    err_multi_o;
    logic                    err_nodonor_o;

    modport master (
        output in_valid, w_i, out_ready,
        input  in_ready, out_valid, w_o, sel_o, addr_o,
        input  err_multi_o, err_nodonor_o
    );

    modport slave (
        input  in_valid, w_i, out_ready,
        output in_ready, out_valid, w_o, sel_o, addr_o,
        output err_multi_o, err_nodonor_o
    );

endinterface

// File: rtl/lane_prio_enc.sv
// Lane-mask priority encoder: index of the lowest (HIGH=0) or highest
// (HIGH=1) set bit, plus a found flag.
module lane_prio_enc
    import outlier_pkg::*;
#(
    parameter bit HIGH = 1'b0
) (
    input  lane_mask_t mask_i,
    output lane_idx_t  idx_o,
    output logic       found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = |mask_i;
        if (HIGH) begin
            for (int k = 0; k < LANES; k++) begin
                if (mask_i[k]) idx_o = lane_idx_t'(k);
            end
        end else begin
            for (int k = LANES - 1; k >= 0; k--) begin
                if (mask_i[k]) idx_o = lane_idx_t'(k);
            end
        end
    end

endmodule

// File: rtl/outlier_weight_encoder.sv
// Two-stage encoder packing 8x8-bit weights into 8x4-bit lanes + sel/addr.
// Optional statistics counters are built when OUTLIER_ENC_STATS_EN is defined.
module outlier_weight_encoder
    import outlier_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DONOR_HIGH = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    outlier_weight_encoder_if.slave bus,
    input  logic                  stat_clr,
    output logic [CNT_W-1:0]      outlier_cnt_o,
    output logic [CNT_W-1:0]      err_cnt_o
);

    logic s1_valid_q;
    s1_t  s1_q, s1_d;
    logic s2_adv, s1_adv;

    logic                out_valid_q;
    nib_vec_t            w_q, w_d;
    logic                sel_q, sel_d;
    logic [2*ADDR_W-1:0] addr_q, addr_d;
    logic                multi_q, multi_d;
    logic                nodonor_q, nodonor_d;

    assign s2_adv      = !out_valid_q || bus.out_ready;
    assign s1_adv      = s2_adv || !s1_valid_q;
    assign bus.in_ready = !s1_valid_q || s2_adv;

    always_comb begin
        s1_d = '0;
        for (int k = 0; k < LANES; k++) begin
            s1_d.out_mask[k]  = |bus.w_i[LANE_W*k+NIB_W +: NIB_W];
            s1_d.zero_mask[k] = bus.w_i[LANE_W*k +: LANE_W] == '0;
            s1_d.hi[NIB_W*k +: NIB_W] = bus.w_i[LANE_W*k+NIB_W +: NIB_W];
            s1_d.lo[NIB_W*k +: NIB_W] = bus.w_i[LANE_W*k +: NIB_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) s1_q <= s1_d;
        end
    end

    lane_idx_t o_idx, d_idx;
    logic      o_found, d_found;

    lane_prio_enc #(.HIGH(1'b0)) u_out_enc (
        .mask_i  (s1_q.out_mask),
        .idx_o   (o_idx),
        .found_o (o_found)
    );

    lane_prio_enc #(.HIGH(DONOR_HIGH != 0)) u_donor_enc (
        .mask_i  (s1_q.zero_mask),
        .idx_o   (d_idx),
        .found_o (d_found)
    );

    logic [NIB_W-1:0] hi_sel;

    // Donor lane is all-zero, so o != d and lane o keeps its low nibble.
    always_comb begin
        hi_sel    = '0;
        w_d       = s1_q.lo;
        sel_d     = 1'b0;
        addr_d    = '0;
        multi_d   = popcnt(s1_q.out_mask) > 4'd1;
        nodonor_d = o_found && !d_found;
        for (int k = 0; k < LANES; k++) begin
            if (lane_idx_t'(k) == o_idx) hi_sel = s1_q.hi[NIB_W*k +: NIB_W];
        end
        if (o_found && d_found) begin
            sel_d = 1'b1;
            addr_d[OUT_FIELD_LSB +: ADDR_W]   = o_idx;
            addr_d[DONOR_FIELD_LSB +: ADDR_W] = d_idx;
            for (int k = 0; k < LANES; k++) begin
                if (lane_idx_t'(k) == d_idx) w_d[NIB_W*k +: NIB_W] = hi_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            w_q         <= '0;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            multi_q     <= 1'b0;
            nodonor_q   <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                w_q       <= w_d;
                sel_q     <= sel_d;
                addr_q    <= addr_d;
                multi_q   <= multi_d;
                nodonor_q <= nodonor_d;
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.w_o           = w_q;
    assign bus.sel_o         = sel_q;
    assign bus.addr_o        = addr_q;
    assign bus.err_multi_o   = multi_q && out_valid_q;
    assign bus.err_nodonor_o = nodonor_q && out_valid_q;

`ifdef OUTLIER_ENC_STATS_EN
    logic [CNT_W-1:0] ocnt_q, ecnt_q;
    logic             xfer;

    assign xfer = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ocnt_q <= '0;
            ecnt_q <= '0;
        end else if (stat_clr) begin
            ocnt_q <= '0;
            ecnt_q <= '0;
        end else if (xfer) begin
            if (sel_q && !(&ocnt_q)) ocnt_q <= ocnt_q + CNT_W'(1);
            if ((multi_q || nodonor_q) && !(&ecnt_q)) begin
                ecnt_q <= ecnt_q + CNT_W'(1);
            end
        end
    end

    assign outlier_cnt_o = ocnt_q;
    assign err_cnt_o     = ecnt_q;
`else
    logic stats_unused;
    assign stats_unused  = stat_clr;
    assign outlier_cnt_o = '0;
    assign err_cnt_o     = '0;
`endif

endmodule

// File: doc/outlier_weight_encoder.md
Name: outlier_weight_encoder

Overview:
- Packs eight 8-bit unsigned weights into eight 4-bit lanes plus a sel/addr side channel.
- At most one outlier (high nibble nonzero) per beat is carried by borrowing one all-zero lane to hold its high nibble.
- Sits upstream of the PE weight-unpacking stage and produces exactly the {4-bit lanes, sel, addr[5:3]=outlier lane, addr[2:0]=donor lane} format that stage consumes.
- 2-stage valid/ready pipeline, with error flags and optional statistics counters.

Parameters:
- CNT_W, 16, width of the saturating statistics counters (used only when the optional feature is compiled in).
- DONOR_HIGH, 0, donor lane choice: 0 = lowest-index zero lane, 1 = highest-index zero lane.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  encoder can accept a beat.
- w_i  in  64  eight 8-bit weights; lane k = w_i[8k+7:8k].
- out_valid  out  1  packed beat valid.
- out_ready  in  1  downstream accepts.
- w_o  out  32  eight 4-bit lanes; lane k = w_o[4k+3:4k].
- sel_o  out  1  1 = an outlier is encoded in this beat.
- addr_o  out  6  [5:3] outlier lane, [2:0] donor lane; 0 when sel_o=0.
- err_multi_o  out  1  beat had more than one outlier.
- err_nodonor_o  out  1  beat had an outlier and no zero lane.
- stat_clr  in  1  synchronous clear of the counters (ignored if the feature is compiled out).
- outlier_cnt_o  out  CNT_W  encoded outliers (ties 0 if the feature is compiled out).
- err_cnt_o  out  CNT_W  errored beats (ties 0 if the feature is compiled out).

Behaviour:
- Reset: all pipeline valids 0 and all data/flag registers 0. out_valid=0, w_o=0, sel_o=0, addr_o=0, err_*=0, counters=0. in_ready=1 one cycle after reset release.
- Stage 1 (S1), registered on an accepted beat:
  - out_mask[k] = |w_i[8k+7:8k+4].
  - zero_mask[k] = (w_i lane k == 8'd0).
  - Low nibbles of all lanes.
- Stage 2 (S2), computed from S1 registers and registered into the outputs:
  - o = lowest-index set bit of out_mask.
  - d = per DONOR_HIGH, selected from zero_mask.
  - Encode case (out_mask != 0 and zero_mask != 0):
    - sel_o=1, addr_o={o,d}.
    - w_o lane d = high nibble of lane o.
    - Every other lane = its low nibble.
    - Lane o keeps its low nibble.
  - Invariant: o != d always holds, because an outlier lane is never zero.
  - No-outlier case: sel_o=0, addr_o=0, w_o = low nibbles.
  - out_mask != 0 and zero_mask == 0: sel_o=0, addr_o=0, w_o = low nibbles (outliers truncated), err_nodonor_o=1.
  - popcount(out_mask) > 1: err_multi_o=1. Lane o is still encoded if a donor exists; other outliers are truncated to their low nibble.
  - err_* are qualified by out_valid and held with the beat.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - S2 advances when !out_valid || out_ready.
  - S1 advances when S2 advances or S1 is empty.
  - in_ready = !s1_valid || s2_adv (combinational from out_ready; no skid).
  - While out_valid=1 && out_ready=0, w_o/sel_o/addr_o/err_* hold stable.
- Latency: 2 cycles from in_valid&&in_ready to out_valid. Throughput 1 beat/cycle when out_ready=1. Bubbles are preserved, not compressed.
- Reset mid-operation discards all in-flight beats; no partial output.

Optional Feature:
- Macro: OUTLIER_ENC_STATS_EN.
- Defined:
  - outlier_cnt_o increments on each output transfer with sel_o=1.
  - err_cnt_o increments on each output transfer with err_multi_o or err_nodonor_o set (counts once per beat).
  - Both saturate at all-ones.
  - stat_clr has priority over an increment in the same cycle.
- Undefined: no counter flops; outputs tie to 0; stat_clr unused.

Decomposition:
- Package outlier_pkg:
  - LANES=8, LANE_W=8, NIB_W=4, ADDR_W=3.
  - Field offsets: OUT_FIELD_LSB=3, DONOR_FIELD_LSB=0.
  - lane_mask_t typedef.
  - Shared with the unpacker bench.
- Sub-module lane_prio_enc: 8-bit mask to 3-bit index plus found flag, parameterised low/high priority. Instantiated twice (outlier, donor).

Test Plan:
- w_i lanes={0x05,0x00,0x03,0x2A,0x01,0x00,0x07,0x04} (lane0 first) -> after 2 cycles sel_o=1, addr_o={3,1}=6'o31, w_o lanes={5,2,3,A,1,0,7,4}, no errors.
- All lanes high nibble 0, e.g. {1..8} -> sel_o=0, addr_o=0, w_o = low nibbles, no errors.
- Lane2=0x9C, no zero lanes (others 0x01) -> sel_o=0, w_o lane2=0xC, err_nodonor_o=1.
- Lane1=0x30, lane6=0x45, lane4=0x00, rest 0x01 -> addr_o={1,4}, w_o lane4=3, lane6=5, err_multi_o=1.
- Burst of 4 beats with out_ready=0 for cycles 3-5 -> in_ready drops once both stages are full, output held stable, all 4 beats emerge in order with no loss or duplication.
- With OUTLIER_ENC_STATS_EN defined: 3 encoded beats plus 1 error beat -> outlier_cnt_o=3, err_cnt_o=1. stat_clr asserted with a concurrent increment -> both counters 0. Repeat with CNT_W=2 to check saturation at 3.
